// File: rtl/pixel_blend_pipe.sv
// pixel_blend_pipe
// Weighted blend of two pixel beats: out = round((A*wgt_a + B*wgt_b) >> SHIFT).
// Both products are formed by shift-and-add over WGT_W cycles, one weight bit
// per cycle, with all CH channels advancing in lock-step.
// Optional feature macro: BLEND_SAT_EN (clamp instead of wrap on overflow).
//
// Handshake (both ports): a beat moves on a rising edge where valid && ready
// are both high; valid and payload stay asserted and stable until that edge,
// and ready may depend on state only, never combinationally on valid.
//
// dbg_state exposes the FSM state (IDLE=0, MULT=1, DONE=2) for checkers.

module pixel_blend_pipe #(
    parameter int PIX_W = 8,
    parameter int WGT_W = 4,
    parameter int CH    = 1,
    parameter int SHIFT = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CH*PIX_W-1:0] pix_a,
    input  logic [CH*PIX_W-1:0] pix_b,
    input  logic [WGT_W-1:0]    wgt_a,
    input  logic [WGT_W-1:0]    wgt_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH*PIX_W-1:0] out_pix,
    output logic                busy,
    output logic [1:0]          dbg_state
);

    // Accumulator holds the full sum of both products without overflow;
    // the rounding adder gets one more bit so the bias cannot wrap.
    localparam int AW     = PIX_W + WGT_W + 1;
    localparam int RW     = AW + 1;
    localparam int CW     = $clog2(WGT_W + 1);
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic [RW-1:0] RND  = (SHIFT > 0) ? (RW'(1) << RND_SH) : '0;
    localparam logic [CW-1:0] LAST = CW'(WGT_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     cnt;
    logic [WGT_W-1:0]  wa_sh;
    logic [WGT_W-1:0]  wb_sh;
    logic [AW-1:0]     a_sh [CH];
    logic [AW-1:0]     b_sh [CH];
    logic [AW-1:0]     acc  [CH];
    logic [PIX_W-1:0]  res  [CH];
    logic              accept;

    assign accept    = in_valid && (state == IDLE);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: MULT runs WGT_W add cycles plus one result-register cycle
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid)     state_nxt = MULT;
            MULT: if (cnt == LAST)  state_nxt = DONE;
            DONE: if (out_ready)    state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Round-half-up normalisation, then wrap or clamp to PIX_W bits
`ifdef BLEND_SAT_EN
    logic [RW-1:0] rnd_shf [CH];
    localparam logic [RW-1:0] PIX_MAX = {{(RW-PIX_W){1'b0}}, {PIX_W{1'b1}}};

    always_comb begin
        for (int k = 0; k < CH; k++) begin
            rnd_shf[k] = ({1'b0, acc[k]} + RND) >> SHIFT;
            res[k]     = (rnd_shf[k] > PIX_MAX) ? {PIX_W{1'b1}}
                                                : rnd_shf[k][PIX_W-1:0];
        end
    end
`else
    always_comb begin
        for (int k = 0; k < CH; k++) begin
            res[k] = PIX_W'(({1'b0, acc[k]} + RND) >> SHIFT);
        end
    end
`endif

    // Datapath: capture on accept, shift-and-add in MULT, register result on the last MULT cycle.
    // Weights shift right so bit 0 is always the current bit; operands shift left to match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            wa_sh   <= '0;
            wb_sh   <= '0;
            out_pix <= '0;
            for (int k = 0; k < CH; k++) begin
                a_sh[k] <= '0;
                b_sh[k] <= '0;
                acc[k]  <= '0;
            end
        end else if (accept) begin
            cnt   <= '0;
            wa_sh <= wgt_a;
            wb_sh <= wgt_b;
            for (int k = 0; k < CH; k++) begin
                a_sh[k] <= AW'(pix_a[k*PIX_W +: PIX_W]);
                b_sh[k] <= AW'(pix_b[k*PIX_W +: PIX_W]);
                acc[k]  <= '0;
            end
        end else if (state == MULT) begin
            if (cnt != LAST) begin
                cnt   <= cnt + CW'(1);
                wa_sh <= wa_sh >> 1;
                wb_sh <= wb_sh >> 1;
                for (int k = 0; k < CH; k++) begin
                    a_sh[k] <= a_sh[k] << 1;
                    b_sh[k] <= b_sh[k] << 1;
                    acc[k]  <= acc[k] + (wa_sh[0] ? a_sh[k] : '0)
                                      + (wb_sh[0] ? b_sh[k] : '0);
                end
            end else begin
                for (int k = 0; k < CH; k++) begin
                    out_pix[k*PIX_W +: PIX_W] <= res[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_blend_pipe.sv
// tb_pixel_blend_pipe
// Self-checking bench for pixel_blend_pipe at PIX_W=8, WGT_W=4, SHIFT=3, CH=3.
// Directed beats cover the worked examples; random beats are scored against
// an arithmetic model of the blend. Honours BLEND_SAT_EN in the model.

module tb_pixel_blend_pipe;

    localparam int PIX_W = 8;
    localparam int WGT_W = 4;
    localparam int CH    = 3;
    localparam int SHIFT = 3;
    localparam int PW    = CH * PIX_W;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] pix_a;
    logic [PW-1:0] pix_b;
    logic [WGT_W-1:0] wgt_a;
    logic [WGT_W-1:0] wgt_b;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_pix;
    logic          busy;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [PW-1:0] exp_q[$];

    pixel_blend_pipe #(
        .PIX_W(PIX_W), .WGT_W(WGT_W), .CH(CH), .SHIFT(SHIFT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .pix_a(pix_a), .pix_b(pix_b), .wgt_a(wgt_a), .wgt_b(wgt_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
        .busy(busy), .dbg_state(dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: per channel (A*wa + B*wb + 2^(SHIFT-1)) / 2^SHIFT, then clamp or wrap
    function automatic logic [PW-1:0] model(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                            input logic [WGT_W-1:0] wa, input logic [WGT_W-1:0] wb);
        logic [PW-1:0] r;
        int s;
        int q;
        r = '0;
        for (int k = 0; k < CH; k++) begin
            s = int'(a[k*PIX_W +: PIX_W]) * int'(wa) + int'(b[k*PIX_W +: PIX_W]) * int'(wb);
            q = (s + (1 << (SHIFT - 1))) / (1 << SHIFT);
`ifdef BLEND_SAT_EN
            if (q > (1 << PIX_W) - 1) q = (1 << PIX_W) - 1;
`endif
            r[k*PIX_W +: PIX_W] = PIX_W'(q % (1 << PIX_W));
        end
        return r;
    endfunction

    task automatic scramble_inputs();
        pix_a = PW'($urandom);
        pix_b = PW'($urandom);
        wgt_a = WGT_W'($urandom);
        wgt_b = WGT_W'($urandom);
    endtask

    // Driver + checker for one full beat: accept, latency, hold under back-pressure, handshake
    task automatic run_beat(input string tag, input logic [PW-1:0] a, input logic [PW-1:0] b,
                            input logic [WGT_W-1:0] wa, input logic [WGT_W-1:0] wb,
                            input logic [PW-1:0] exp, input int hold);
        int lat;
        bit seen;
        logic [PW-1:0] want;
        check({tag, " ready_before"}, 64'(in_ready), 64'd1);
        check({tag, " busy_before"}, 64'(busy), 64'd0);
        pix_a = a; pix_b = b; wgt_a = wa; wgt_b = wb;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble_inputs();
        check({tag, " busy_after_accept"}, 64'(busy), 64'd1);
        check({tag, " ready_after_accept"}, 64'(in_ready), 64'd0);
        lat  = 0;
        seen = 1'b0;
        for (int e = 1; e <= 20 && !seen; e++) begin
            @(posedge clk); #1;
            scramble_inputs();
            if (out_valid) begin
                seen = 1'b1;
                lat  = e;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'(WGT_W + 1));
        want = exp_q.pop_front();
        check({tag, " out_pix"}, 64'(out_pix), 64'(want));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            scramble_inputs();
            check({tag, " hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, " hold_pix"}, 64'(out_pix), 64'(want));
            check({tag, " hold_ready"}, 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " valid_dropped"}, 64'(out_valid), 64'd0);
        check({tag, " busy_dropped"}, 64'(busy), 64'd0);
        check({tag, " ready_back"}, 64'(in_ready), 64'd1);
    endtask

    // Stimulus sequence
    initial begin
        logic [PW-1:0] a;
        logic [PW-1:0] b;
        logic [WGT_W-1:0] wa;
        logic [WGT_W-1:0] wb;
        logic [PW-1:0] sat_exp;
        int stray;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        pix_a = '0; pix_b = '0; wgt_a = '0; wgt_b = '0;
        #12;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_pix", 64'(out_pix), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Worked examples
        run_beat("ex_200_100", {8'd0, 8'd0, 8'd200}, {8'd0, 8'd0, 8'd100}, 4'd3, 4'd7,
                 {8'd0, 8'd0, 8'd163}, 0);
`ifdef BLEND_SAT_EN
        sat_exp = {3{8'd255}};
`else
        sat_exp = {3{8'd188}};
`endif
        run_beat("max_overflow", {3{8'd255}}, {3{8'd255}}, 4'd15, 4'd15, sat_exp, 1);
        a = PW'($urandom); b = PW'($urandom);
        run_beat("zero_wgt", a, b, 4'd0, 4'd0, '0, 2);
        run_beat("backpressure", {8'd0, 8'd0, 8'd200}, {8'd0, 8'd0, 8'd100}, 4'd3, 4'd7,
                 {8'd0, 8'd0, 8'd163}, 6);
        run_beat("three_ch", {8'd30, 8'd20, 8'd10}, {8'd60, 8'd50, 8'd40}, 4'd4, 4'd4,
                 {8'd45, 8'd35, 8'd25}, 0);
        run_beat("one_wgt", {8'd1, 8'd3, 8'd255}, {8'd0, 8'd0, 8'd0}, 4'd1, 4'd0,
                 {8'd0, 8'd0, 8'd32}, 0);

        // Reset in the middle of MULT: beat must vanish
        pix_a = {8'd9, 8'd8, 8'd7}; pix_b = {8'd1, 8'd2, 8'd3};
        wgt_a = 4'd5; wgt_b = 4'd6;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midrst busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst out_pix", 64'(out_pix), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (out_valid) stray++;
        end
        check("midrst no_beat", 64'(stray), 64'd0);
        check("midrst ready_after", 64'(in_ready), 64'd1);

        // Randomized beats against the model
        for (int n = 0; n < 40; n++) begin
            a  = PW'($urandom);
            b  = PW'($urandom);
            wa = WGT_W'($urandom_range(0, 15));
            wb = WGT_W'($urandom_range(0, 15));
            run_beat("random", a, b, wa, wb, model(a, b, wa, wb), $urandom_range(0, 3));
        end

        check("scoreboard empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
